memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 37 +++
 rtl/memory_responder.sv | 119 +++++++++++
 tb/tb_memory_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// Command/response bus between an initiator and the memory responder.
// Writes are fire-and-forget; reads return in acceptance order.
interface memory_responder_if;
  logic        bus_cmd_valid;
  logic        bus_cmd_ready;
  logic [31:0] bus_cmd_payload_address;
  logic        bus_cmd_payload_write;
  logic [31:0] bus_cmd_payload_wdata;
  logic [3:0]  bus_cmd_payload_wmask;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready;
  logic [31:0] bus_rsp_payload_rdata;

  modport master (
    output bus_cmd_valid,
    output bus_cmd_payload_address,
    output bus_cmd_payload_write,
    output bus_cmd_payload_wdata,
    output bus_cmd_payload_wmask,
    output bus_rsp_ready,
    input  bus_cmd_ready,
    input  bus_rsp_valid,
    input  bus_rsp_payload_rdata
  );

  modport slave (
    input  bus_cmd_valid,
    input  bus_cmd_payload_address,
    input  bus_cmd_payload_write,
    input  bus_cmd_payload_wdata,
    input  bus_cmd_payload_wmask,
    input  bus_rsp_ready,
    output bus_cmd_ready,
    output bus_rsp_valid,
    output bus_rsp_payload_rdata
  );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed memory with byte-masked writes and credit-limited reads.
// Read data runs through a fixed delay line into a small response FIFO.
module memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  memory_responder_if.slave bus,
  output logic              error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 4;

  logic [AW-1:0] idx;
  logic          in_range;
  logic          cmd_fire;
  logic          wr_fire;
  logic          rd_fire;
  logic          unused_addr_bits;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [LATENCY-1:0] dl_valid;
  logic [31:0]        dl_data [LATENCY];

  logic [31:0]   fifo [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   occ;
  logic          push;
  logic          pop;
  logic [CW-1:0] credits;

  assign idx      = bus.bus_cmd_payload_address[AW+1:2];
  assign in_range = bus.bus_cmd_payload_address[31:AW+2] == '0;
  assign unused_addr_bits = ^bus.bus_cmd_payload_address[1:0];

  // Every read in flight or queued holds one response slot.
  always_comb begin
    credits = CW'(occ);
    for (int i = 0; i < LATENCY; i++) begin
      credits = credits + CW'(dl_valid[i]);
    end
  end

  assign bus.bus_cmd_ready = bus.bus_cmd_payload_write ||
                             (credits < CW'(RSP_DEPTH));

  assign cmd_fire = bus.bus_cmd_valid && bus.bus_cmd_ready;
  assign wr_fire  = cmd_fire && bus.bus_cmd_payload_write && in_range;
  assign rd_fire  = cmd_fire && !bus.bus_cmd_payload_write;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bus_cmd_payload_wmask[b]) begin
          mem[idx][8*b +: 8] <= bus.bus_cmd_payload_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= rd_fire;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_data[0] <= in_range ? mem[idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      dl_data[i] <= dl_data[i-1];
    end
  end

  assign push = dl_valid[LATENCY-1];
  assign pop  = (occ != '0) && bus.bus_rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= dl_data[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign bus.bus_rsp_valid = occ != '0;
  assign bus.bus_rsp_payload_rdata =
    bus.bus_rsp_valid ? fifo[rd_ptr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (cmd_fire && !in_range) begin
      error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed vectors, backpressure and reset
// sequences, then randomized traffic against a queue-based model.
module tb_memory_responder;
  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int RSP_DEPTH   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic error;

  memory_responder_if bus();

  memory_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY(LATENCY),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit ovf    = 1'b0;

  always @(posedge clk) begin
    if (reset && dut.push && !dut.pop && dut.occ == RSP_DEPTH) begin
      ovf <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    bus.bus_cmd_valid           = v;
    bus.bus_cmd_payload_write   = w;
    bus.bus_cmd_payload_address = a;
    bus.bus_cmd_payload_wdata   = d;
    bus.bus_cmd_payload_wmask   = m;
  endtask

  task automatic send(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m,
                      output bit acc);
    drive(1'b1, w, a, d, m);
    @(negedge clk);
    acc = bus.bus_cmd_ready;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] exp);
    int j;
    j = 0;
    @(negedge clk);
    while (!bus.bus_rsp_valid && j < 20) begin
      j++;
      @(negedge clk);
    end
    chk({name, "_lat"}, j, LATENCY);
    chk({name, "_data"}, bus.bus_rsp_payload_rdata, exp);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          elig;
  } exp_t;

  vec_t        vecs [17];
  logic [31:0] ra [6];
  logic [31:0] re [6];
  logic [31:0] mm [16];
  exp_t        q [$];

  initial begin
    bit acc;
    int n;
    int k;
    bit seen;
    int cyc;
    bit err_m;

    vecs[0]  = '{1, 32'h10,       32'h11223344, 4'hF, 32'h0,        0};
    vecs[1]  = '{0, 32'h10,       32'h0,        4'h0, 32'h11223344, 0};
    vecs[2]  = '{1, 32'h10,       32'hAABBCCDD, 4'h5, 32'h0,        0};
    vecs[3]  = '{0, 32'h10,       32'h0,        4'h0, 32'h11BB33DD, 0};
    vecs[4]  = '{1, 32'h13,       32'h00000000, 4'h0, 32'h0,        0};
    vecs[5]  = '{0, 32'h12,       32'h0,        4'h0, 32'h11BB33DD, 0};
    vecs[6]  = '{1, 32'hFFC,      32'hDEADBEEF, 4'hF, 32'h0,        0};
    vecs[7]  = '{0, 32'hFFC,      32'h0,        4'h0, 32'hDEADBEEF, 0};
    vecs[8]  = '{1, 32'h14,       32'hFFFFFFFF, 4'hF, 32'h0,        0};
    vecs[9]  = '{1, 32'h14,       32'h12345678, 4'hA, 32'h0,        0};
    vecs[10] = '{0, 32'h14,       32'h0,        4'h0, 32'h12FF56FF, 0};
    vecs[11] = '{1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        0};
    vecs[12] = '{1, 32'h1000,     32'h55555555, 4'hF, 32'h0,        1};
    vecs[13] = '{0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1};
    vecs[14] = '{0, 32'h1000,     32'h0,        4'h0, 32'h00000000, 1};
    vecs[15] = '{0, 32'h80000010, 32'h0,        4'h0, 32'h00000000, 1};
    vecs[16] = '{0, 32'h10,       32'h0,        4'h0, 32'h11BB33DD, 1};

    ra = '{32'h0, 32'h10, 32'h14, 32'hFFC, 32'h0, 32'h14};
    re = '{32'hCAFEF00D, 32'h11BB33DD, 32'h12FF56FF,
           32'hDEADBEEF, 32'hCAFEF00D, 32'h12FF56FF};

    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.bus_rsp_ready = 1'b1;

    #12;
    chk("rst_rsp_valid", bus.bus_rsp_valid, 0);
    chk("rst_rdata", bus.bus_rsp_payload_rdata, 0);
    chk("rst_error", error, 0);
    chk("rst_cmd_ready", bus.bus_cmd_ready, 1);
    @(posedge clk);
    #1 reset = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].mask, acc);
      chk($sformatf("vec%0d_accept", i), acc, 1);
      if (!vecs[i].wr) begin
        wait_rsp($sformatf("vec%0d", i), vecs[i].exp);
      end
      chk($sformatf("vec%0d_error", i), error, vecs[i].exp_err);
    end

    // Backpressure: only RSP_DEPTH reads may be outstanding.
    bus.bus_rsp_ready = 1'b0;
    n = 0;
    for (int t = 0; t < 12; t++) begin
      drive(n < 6, 1'b0, ra[n < 6 ? n : 0], 32'h0, 4'h0);
      @(negedge clk);
      if (bus.bus_cmd_valid && bus.bus_cmd_ready) n++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepted", n, 4);
    drive(1'b1, 1'b0, ra[4], 32'h0, 4'h0);
    @(negedge clk);
    chk("bp_read_blocked", bus.bus_cmd_ready, 0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    chk("bp_write_ready", bus.bus_cmd_ready, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, ra[4], 32'h0, 4'h0);
    bus.bus_rsp_ready = 1'b1;
    k = 0;
    @(negedge clk);
    chk("pop_credit_delay", bus.bus_cmd_ready, 0);
    if (bus.bus_rsp_valid) begin
      chk("bp_rsp0", bus.bus_rsp_payload_rdata, re[0]);
      k++;
    end
    @(posedge clk);
    #1;
    for (int t = 0; t < 40 && k < 6; t++) begin
      drive(n < 6, 1'b0, ra[n < 6 ? n : 0], 32'h0, 4'h0);
      @(negedge clk);
      if (bus.bus_cmd_valid && bus.bus_cmd_ready) n++;
      if (bus.bus_rsp_valid) begin
        chk($sformatf("bp_rsp%0d", k), bus.bus_rsp_payload_rdata, re[k]);
        k++;
      end
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("bp_rsp_count", k, 6);
    chk("bp_all_accepted", n, 6);
    send(1'b0, 32'h20, 32'h0, 4'h0, acc);
    wait_rsp("bp_write_read", 32'h0BADF00D);

    // Reset with reads in flight.
    bus.bus_rsp_ready = 1'b0;
    send(1'b0, 32'h0, 32'h0, 4'h0, acc);
    send(1'b0, 32'h10, 32'h0, 4'h0, acc);
    send(1'b0, 32'h14, 32'h0, 4'h0, acc);
    @(negedge clk);
    chk("pre_reset_valid", bus.bus_rsp_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("reset_valid", bus.bus_rsp_valid, 0);
    chk("reset_rdata", bus.bus_rsp_payload_rdata, 0);
    chk("reset_error", error, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.bus_rsp_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.bus_rsp_valid) seen = 1'b1;
    end
    chk("no_stale_rsp", seen, 0);
    chk("post_reset_ready", bus.bus_cmd_ready, 1);
    @(posedge clk);
    #1;
    send(1'b0, 32'h0, 32'h0, 4'h0, acc);
    wait_rsp("mem_kept", 32'hCAFEF00D);

    // Randomized traffic against the model.
    cyc = 0;
    err_m = 1'b0;
    for (int c = 0; c < 10050; c++) begin
      bit          v;
      bit          w;
      bit          rr;
      bit          exp_rdy;
      bit          exp_val;
      bit          inr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      logic [31:0] rd;
      if (c < 16) begin
        v = 1; w = 1; a = 32'(c) * 4; d = $urandom; m = 4'hF;
      end else if (c >= 10000) begin
        v = 0; w = 0; a = 0; d = 0; m = 0;
      end else begin
        v = $urandom_range(0, 9) < 6;
        w = $urandom_range(0, 9) < 4;
        if ($urandom_range(0, 15) == 0) a = $urandom | 32'h1000;
        else a = 32'($urandom_range(0, 63));
        d = $urandom;
        m = 4'($urandom_range(0, 15));
      end
      rr = (c >= 10000) ? 1'b1 : ($urandom_range(0, 9) < 7);
      drive(v, w, a, d, m);
      bus.bus_rsp_ready = rr;
      @(negedge clk);
      exp_rdy = w || (q.size() < RSP_DEPTH);
      exp_val = q.size() > 0 && q[0].elig <= cyc;
      chk("rnd_cmd_ready", bus.bus_cmd_ready, exp_rdy);
      chk("rnd_rsp_valid", bus.bus_rsp_valid, exp_val);
      if (exp_val) chk("rnd_rdata", bus.bus_rsp_payload_rdata, q[0].data);
      chk("rnd_error", error, err_m);
      if (exp_val && rr) void'(q.pop_front());
      if (v && exp_rdy) begin
        inr = a[31:12] == 0;
        if (!inr) err_m = 1'b1;
        if (w && inr) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) mm[a[5:2]][8*b +: 8] = d[8*b +: 8];
        end else if (!w) begin
          rd = inr ? mm[a[5:2]] : 32'h0;
          q.push_back('{rd, cyc + 1 + LATENCY});
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rnd_drained", q.size(), 0);
    chk("no_overflow", ovf, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
